// File: rtl/udp_axis_pkg.sv
// udp_axis_pkg: shared types and helpers for the byte/word AXI-Stream converters
// Provides the word size in bytes, the byte-index type and the lane-keep helper.
package udp_axis_pkg;
    localparam int BYTES_PER_WORD = 4;
    typedef logic [1:0] byte_idx_t;
    // keep mask for cnt+1 valid bytes; msb_first mirrors the lanes
    function automatic logic [3:0] keep_from_count(byte_idx_t cnt, logic msb_first);
        logic [3:0] k;
        k = cnt == 2'd0 ? 4'b0001 : cnt == 2'd1 ? 4'b0011 : cnt == 2'd2 ? 4'b0111 : 4'b1111;
        return msb_first ? {k[0], k[1], k[2], k[3]} : k;
    endfunction
endpackage

// File: rtl/axis8to32.sv
// axis8to32: packs an 8-bit AXI-Stream into 32-bit words with tkeep and reports frame length
// Ports: clk/reset (sync, active-high); axis_*_in byte input with axis_tready_out;
// axis_*_out packed word output with axis_tready_in; frame_len_out/frame_done_out length report.
module axis8to32
    import udp_axis_pkg::*;
#(
    parameter bit FIRST_BYTE_MSB = 1'b0,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       axis_tdata_in,
    input  logic             axis_tvalid_in,
    input  logic             axis_tlast_in,
    output logic             axis_tready_out,
    output logic [31:0]      axis_tdata_out,
    output logic [3:0]       axis_tkeep_out,
    output logic             axis_tvalid_out,
    output logic             axis_tlast_out,
    input  logic             axis_tready_in,
    output logic [LEN_W-1:0] frame_len_out,
    output logic             frame_done_out
);
    byte_idx_t cnt, lane;
    logic [31:0] acc, acc_next;
    logic [LEN_W-1:0] run, run_inc;
    logic in_beat, emit;
    assign axis_tready_out = !axis_tvalid_out || axis_tready_in;
    assign in_beat = axis_tvalid_in && axis_tready_out;
    assign emit = in_beat && (cnt == byte_idx_t'(BYTES_PER_WORD - 1) || axis_tlast_in);
    // 3-cnt on a 2-bit index is its bitwise inverse
    assign lane = FIRST_BYTE_MSB ? ~cnt : cnt;
    assign acc_next = acc | ({24'd0, axis_tdata_in} << {lane, 3'b000});
    assign run_inc = &run ? run : run + 1'b1;
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            acc <= '0;
            run <= '0;
            axis_tdata_out <= '0;
            axis_tkeep_out <= '0;
            axis_tvalid_out <= 1'b0;
            axis_tlast_out <= 1'b0;
            frame_len_out <= '0;
            frame_done_out <= 1'b0;
        end else begin
            frame_done_out <= 1'b0;
            if (emit) begin
                axis_tdata_out <= acc_next;
                axis_tkeep_out <= keep_from_count(cnt, FIRST_BYTE_MSB);
                axis_tlast_out <= axis_tlast_in;
                axis_tvalid_out <= 1'b1;
                acc <= '0;
                cnt <= '0;
            end else begin
                if (axis_tvalid_out && axis_tready_in) axis_tvalid_out <= 1'b0;
                if (in_beat) begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
            end
            if (in_beat) begin
                run <= axis_tlast_in ? '0 : run_inc;
                if (axis_tlast_in) begin
                    frame_len_out <= run_inc;
                    frame_done_out <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis8to32.sv
// tb_axis8to32: self-checking bench for axis8to32 (lsb-first, msb-first and 4-bit length variants)
module tb_axis8to32;
    typedef struct packed {
        logic [31:0] b;
        logic [2:0]  n;
        logic        l;
    } w_t;
    typedef struct packed {
        logic        v;
        logic [7:0]  d;
        logic        l;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  ek;
        logic        el;
        logic        edn;
        logic [15:0] elen;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, ain = 1'b0, lin = 1'b0, rdy = 1'b1;
    logic [7:0] din = 8'h00;
    logic [31:0] d_o[3];
    logic [3:0] k_o[3];
    logic [2:0] vo, lo, fd, tr;
    logic [15:0] len0, len1;
    logic [3:0] len2;
    int n_cmp = 0, n_fail = 0;
    logic [7:0] part[$];
    w_t wq[$];
    int lq[$];
    int run_len = 0;
    bit stall = 1'b0;
    logic [31:0] hd[3];
    logic [3:0] hk[3];
    logic [2:0] hl;
    vec_t tbl[$];

    always #5 clk = ~clk;

    axis8to32 #(.FIRST_BYTE_MSB(1'b0), .LEN_W(16)) dut0 (
        .clk(clk), .reset(reset), .axis_tdata_in(din), .axis_tvalid_in(ain), .axis_tlast_in(lin),
        .axis_tready_out(tr[0]), .axis_tdata_out(d_o[0]), .axis_tkeep_out(k_o[0]),
        .axis_tvalid_out(vo[0]), .axis_tlast_out(lo[0]), .axis_tready_in(rdy),
        .frame_len_out(len0), .frame_done_out(fd[0]));
    axis8to32 #(.FIRST_BYTE_MSB(1'b1), .LEN_W(16)) dut1 (
        .clk(clk), .reset(reset), .axis_tdata_in(din), .axis_tvalid_in(ain), .axis_tlast_in(lin),
        .axis_tready_out(tr[1]), .axis_tdata_out(d_o[1]), .axis_tkeep_out(k_o[1]),
        .axis_tvalid_out(vo[1]), .axis_tlast_out(lo[1]), .axis_tready_in(rdy),
        .frame_len_out(len1), .frame_done_out(fd[1]));
    axis8to32 #(.FIRST_BYTE_MSB(1'b0), .LEN_W(4)) dut2 (
        .clk(clk), .reset(reset), .axis_tdata_in(din), .axis_tvalid_in(ain), .axis_tlast_in(lin),
        .axis_tready_out(tr[2]), .axis_tdata_out(d_o[2]), .axis_tkeep_out(k_o[2]),
        .axis_tvalid_out(vo[2]), .axis_tlast_out(lo[2]), .axis_tready_in(rdy),
        .frame_len_out(len2), .frame_done_out(fd[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(w_t w, bit msb);
        logic [31:0] r = '0;
        for (int i = 0; i < int'(w.n); i++) r[8*(msb ? 3 - i : i) +: 8] = w.b[8*i +: 8];
        return r;
    endfunction

    function automatic logic [3:0] keep_of(w_t w, bit msb);
        logic [3:0] lsb = 4'hF >> (3'd4 - w.n);
        logic [3:0] msk = 4'hF << (3'd4 - w.n);
        return msb ? msk : lsb;
    endfunction

    // reference model and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        w_t w;
        int n;
        if (reset) begin
            part.delete();
            wq.delete();
            lq.delete();
            run_len = 0;
            stall = 1'b0;
        end else begin
            if (stall) for (int i = 0; i < 3; i++) begin
                chk("hold_valid", {31'd0, vo[i]}, 32'd1);
                chk("hold_data", d_o[i], hd[i]);
                chk("hold_keep", {28'd0, k_o[i]}, {28'd0, hk[i]});
                chk("hold_last", {31'd0, lo[i]}, {31'd0, hl[i]});
            end
            stall = vo[0] && !rdy;
            for (int i = 0; i < 3; i++) begin
                hd[i] = d_o[i];
                hk[i] = k_o[i];
                hl[i] = lo[i];
            end
            if (vo[0] && rdy) begin
                if (wq.size() == 0) chk("spurious_word", {31'd0, vo[0]}, 32'd0);
                else begin
                    w = wq.pop_front();
                    for (int i = 0; i < 3; i++) begin
                        chk("word_valid", {31'd0, vo[i]}, 32'd1);
                        chk("word_data", d_o[i], pack(w, i == 1));
                        chk("word_keep", {28'd0, k_o[i]}, {28'd0, keep_of(w, i == 1)});
                        chk("word_last", {31'd0, lo[i]}, {31'd0, w.l});
                    end
                end
            end
            if (fd[0]) begin
                chk("done_with_last", {31'd0, vo[0] && lo[0]}, 32'd1);
                if (lq.size() == 0) chk("spurious_done", {31'd0, fd[0]}, 32'd0);
                else begin
                    n = lq.pop_front();
                    chk("len_lsb", {16'd0, len0}, 32'(n));
                    chk("len_msb", {16'd0, len1}, 32'(n));
                    chk("len_sat", {28'd0, len2}, 32'(n > 15 ? 15 : n));
                    chk("done_msb", {31'd0, fd[1]}, 32'd1);
                    chk("done_sat", {31'd0, fd[2]}, 32'd1);
                end
            end
            if (ain && tr[0]) begin
                part.push_back(din);
                run_len++;
                if (part.size() == 4 || lin) begin
                    w = '0;
                    foreach (part[i]) w.b[8*i +: 8] = part[i];
                    w.n = 3'(part.size());
                    w.l = lin;
                    wq.push_back(w);
                    part.delete();
                end
                if (lin) begin
                    lq.push_back(run_len);
                    run_len = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        ain = 1'b1;
        din = d;
        lin = l;
        #1;
        while (!tr[0] && t < 100) begin
            tick();
            t++;
        end
        if (t >= 100) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: byte %h not accepted within 100 cycles", d);
        end
        tick();
        ain = 1'b0;
        lin = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_valid"}, {31'd0, vo[i]}, 32'd0);
            chk({nm, "_data"}, d_o[i], 32'd0);
            chk({nm, "_keep"}, {28'd0, k_o[i]}, 32'd0);
            chk({nm, "_last"}, {31'd0, lo[i]}, 32'd0);
            chk({nm, "_done"}, {31'd0, fd[i]}, 32'd0);
        end
        chk({nm, "_len0"}, {16'd0, len0}, 32'd0);
        chk({nm, "_len1"}, {16'd0, len1}, 32'd0);
        chk({nm, "_len2"}, {28'd0, len2}, 32'd0);
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic l, input logic ev,
                       input logic [31:0] ed, input logic [3:0] ek, input logic el,
                       input logic edn, input logic [15:0] elen);
        tbl.push_back({v, d, l, ev, ed, ek, el, edn, elen});
    endtask

    initial begin
        int k, cyc;
        add(1'b1, 8'h01, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd0);
        add(1'b1, 8'h02, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd0);
        add(1'b1, 8'h03, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd0);
        add(1'b1, 8'h04, 1'b0, 1'b1, 32'h04030201, 4'hF, 1'b0, 1'b0, 16'd0);
        add(1'b1, 8'h05, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd0);
        add(1'b1, 8'h06, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd0);
        add(1'b1, 8'h07, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd0);
        add(1'b1, 8'h08, 1'b1, 1'b1, 32'h08070605, 4'hF, 1'b1, 1'b1, 16'd8);
        add(1'b1, 8'h5A, 1'b1, 1'b1, 32'h0000005A, 4'h1, 1'b1, 1'b1, 16'd1);
        add(1'b1, 8'h10, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd1);
        add(1'b1, 8'h11, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd1);
        add(1'b1, 8'h12, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd1);
        add(1'b1, 8'h13, 1'b1, 1'b1, 32'h13121110, 4'hF, 1'b1, 1'b1, 16'd4);
        add(1'b0, 8'h00, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 16'd4);

        repeat (3) tick();
        chk_zero("reset");
        reset = 1'b0;

        foreach (tbl[i]) begin
            ain = tbl[i].v;
            din = tbl[i].d;
            lin = tbl[i].l;
            tick();
            chk("tbl_valid", {31'd0, vo[0]}, {31'd0, tbl[i].ev});
            chk("tbl_done", {31'd0, fd[0]}, {31'd0, tbl[i].edn});
            chk("tbl_len", {16'd0, len0}, {16'd0, tbl[i].elen});
            if (tbl[i].ev) begin
                chk("tbl_data", d_o[0], tbl[i].ed);
                chk("tbl_keep", {28'd0, k_o[0]}, {28'd0, tbl[i].ek});
                chk("tbl_last", {31'd0, lo[0]}, {31'd0, tbl[i].el});
            end
        end
        ain = 1'b0;
        lin = 1'b0;

        for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0);
        chk("six_w0_lsb", d_o[0], 32'hA3A2A1A0);
        chk("six_w0_msb", d_o[1], 32'hA0A1A2A3);
        chk("six_w0_keep", {28'd0, k_o[1]}, 32'hF);
        send(8'hA4, 1'b0);
        send(8'hA5, 1'b1);
        chk("six_w1_lsb", d_o[0], 32'h0000A5A4);
        chk("six_w1_keep_lsb", {28'd0, k_o[0]}, 32'h3);
        chk("six_w1_msb", d_o[1], 32'hA4A50000);
        chk("six_w1_keep_msb", {28'd0, k_o[1]}, 32'hC);
        chk("six_last", {31'd0, lo[0]}, 32'd1);
        chk("six_len", {16'd0, len0}, 32'd6);
        chk("six_done", {31'd0, fd[0]}, 32'd1);
        tick();

        rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b0);
        ain = 1'b1;
        din = 8'h35;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_ready", {31'd0, tr[0]}, 32'd0);
            chk("bp_valid", {31'd0, vo[0]}, 32'd1);
            chk("bp_data", d_o[0], 32'h34333231);
        end
        rdy = 1'b1;
        tick();
        ain = 1'b0;
        chk("bp_drained", {31'd0, vo[0]}, 32'd0);

        k = 0;
        cyc = 0;
        while (k < 64 && cyc < 2000) begin
            rdy = $urandom_range(0, 2) != 0;
            ain = $urandom_range(0, 3) != 0;
            din = 8'($urandom);
            lin = (k == 63) || ($urandom_range(0, 9) == 0);
            #1;
            if (ain && tr[0]) k++;
            tick();
            cyc++;
        end
        chk("rand_bytes_sent", 32'(k), 32'd64);
        ain = 1'b0;
        lin = 1'b0;
        rdy = 1'b1;
        repeat (5) tick();

        send(8'hEE, 1'b0);
        send(8'hEF, 1'b0);
        reset = 1'b1;
        tick();
        chk_zero("midreset");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h21 + 8'(i), i == 3);
        chk("rst_data", d_o[0], 32'h24232221);
        chk("rst_keep", {28'd0, k_o[0]}, 32'hF);
        chk("rst_last", {31'd0, lo[0]}, 32'd1);
        chk("rst_len", {16'd0, len0}, 32'd4);
        tick();

        for (int i = 0; i < 20; i++) send(8'(i), i == 19);
        chk("sat_len", {28'd0, len2}, 32'd15);
        chk("sat_len_wide", {16'd0, len0}, 32'd20);
        chk("sat_keep", {28'd0, k_o[2]}, 32'hF);
        chk("sat_last", {31'd0, lo[2]}, 32'd1);
        repeat (5) tick();

        chk("words_left", 32'(wq.size()), 32'd0);
        chk("lens_left", 32'(lq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
